// File: rtl/tfhe_pixel_streamer_if.sv
// Valid/ready pixel stream bundle used for both the input and output sides of the streamer.
interface tfhe_pixel_streamer_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       last;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/tfhe_pixel_streamer.sv
// Feeds one pixel at a time into the TFHE slice with per-frame brightness and LFSR keys,
// then returns the slice result on a valid/ready stream with frame and overflow tracking.
module tfhe_pixel_streamer #(
  parameter int        FRAME_PIXELS = 64,
  parameter logic [9:0] SEED1       = 10'h2A5,
  parameter logic [9:0] SEED2       = 10'h1C3,
  parameter bit        SATURATE     = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   brightness,
  tfhe_pixel_streamer_if.slave         pix_in,
  tfhe_pixel_streamer_if.master        pix_out,
  output logic [7:0]                   slice_byte1,
  output logic [9:0]                   slice_pk1,
  output logic [7:0]                   slice_byte2,
  output logic [9:0]                   slice_pk2,
  input  logic [7:0]                   slice_res,
  output logic [15:0]                  ovf_count,
  output logic                         busy
);
  localparam int IDX_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, WAIT} state_t;
  state_t state, state_nxt;

  logic [IDX_W-1:0] idx;
  logic [7:0]       held_bri;
  logic [9:0]       lfsr1, lfsr2;
  logic             out_valid, out_last;
  logic [7:0]       out_data;
  logic             accept, idx_last, ovf;
  logic [8:0]       sum;

  function automatic logic [9:0] lfsr_step(input logic [9:0] q);
    return {q[8:0], q[9] ^ q[6]};
  endfunction

  assign pix_in.ready  = (state == IDLE) & ~rst;
  assign accept        = pix_in.valid & pix_in.ready;
  assign idx_last      = (idx == IDX_W'(FRAME_PIXELS - 1));
  // Overflow is judged on the operands we sent, independent of what the slice returns.
  assign sum           = {1'b0, slice_byte1} + {1'b0, slice_byte2};
  assign ovf           = sum[8];
  assign busy          = (state != IDLE);
  assign pix_out.valid = out_valid;
  assign pix_out.data  = out_data;
  assign pix_out.last  = out_last;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = WAIT;
      WAIT:    if (pix_out.ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      held_bri    <= '0;
      lfsr1       <= SEED1;
      lfsr2       <= SEED2;
      slice_byte1 <= '0;
      slice_byte2 <= '0;
      slice_pk1   <= '0;
      slice_pk2   <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      ovf_count   <= '0;
    end else begin
      if (accept) begin
        slice_byte1 <= pix_in.data;
        if (idx == '0) begin
          slice_byte2 <= brightness;
          held_bri    <= brightness;
        end else begin
          slice_byte2 <= held_bri;
        end
        slice_pk1 <= lfsr1;
        slice_pk2 <= lfsr2;
        lfsr1     <= lfsr_step(lfsr1);
        lfsr2     <= lfsr_step(lfsr2);
      end
      if (state == CAPTURE) begin
        out_valid <= 1'b1;
        out_last  <= idx_last;
        out_data  <= (SATURATE && ovf) ? 8'hFF : slice_res;
        if (ovf && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
      end
      if (state == WAIT && pix_out.ready) begin
        out_valid <= 1'b0;
        if (idx_last) begin
          // Frame wrap: keys and overflow statistics restart with the new frame.
          idx       <= '0;
          lfsr1     <= SEED1;
          lfsr2     <= SEED2;
          ovf_count <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end
endmodule
